// File: rtl/pipe_control_unit_pkg.sv
// Shared types for the pipelined RV32I control unit: opcodes, control-field
// encodings, the per-stage control word and the register-match helpers used
// by the hazard and forwarding logic.
package cu_pkg;

  localparam int unsigned CU_RA_W = 5;
  typedef logic [CU_RA_W-1:0] reg_addr_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_DM  = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Control word carried down the pipe. Register fields are zero whenever
  // the instruction does not read/write them, so a bubble is all zeros.
  typedef struct packed {
    logic      valid;
    alu_op_e   alu_op;
    logic      alu_a_src;
    logic      alu_b_src;
    logic      is_branch;
    logic      is_jump;
    logic [2:0] br_type;
    logic      dm_wr;
    logic [2:0] dm_ctrl;
    logic      ru_wr;
    wb_src_e   wb_src;
    logic      use_rs1;
    logic      use_rs2;
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // True when the producer stage will write register r (x0 never matches).
  function automatic logic writes_reg(ctrl_t producer, reg_addr_t r);
    return producer.valid && producer.ru_wr && (producer.rd != '0) && (producer.rd == r);
  endfunction

  // True when the consumer actually reads a register the producer writes.
  function automatic logic raw_dep(ctrl_t consumer, ctrl_t producer);
    return (consumer.use_rs1 && writes_reg(producer, consumer.rs1)) ||
           (consumer.use_rs2 && writes_reg(producer, consumer.rs2));
  endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// Bundle between the control unit and the datapath: the IF/ID instruction
// fields and pipeline status in, stage control fields and stall/flush out.
interface pipe_control_unit_if #(
  parameter int unsigned RA_W = 5
);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [6:0]      id_funct7;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic            ex_branch_taken;
  logic            mem_stall;

  logic [2:0]      id_imm_src;
  logic            id_illegal;
  logic            stall_pc;
  logic            stall_if_id;
  logic            flush_if_id;
  logic [3:0]      ex_alu_op;
  logic            ex_alu_a_src;
  logic            ex_alu_b_src;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic [2:0]      ex_br_type;
  logic [1:0]      ex_fwd_a;
  logic [1:0]      ex_fwd_b;
  logic            mem_dm_wr;
  logic [2:0]      mem_dm_ctrl;
  logic            wb_ru_wr;
  logic [RA_W-1:0] wb_rd;
  logic [1:0]      wb_data_src;

  // Control unit side.
  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
           ex_branch_taken, mem_stall,
    output id_imm_src, id_illegal, stall_pc, stall_if_id, flush_if_id,
           ex_alu_op, ex_alu_a_src, ex_alu_b_src, ex_is_branch, ex_is_jump,
           ex_br_type, ex_fwd_a, ex_fwd_b, mem_dm_wr, mem_dm_ctrl,
           wb_ru_wr, wb_rd, wb_data_src
  );

  // Datapath side.
  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
           ex_branch_taken, mem_stall,
    input  id_imm_src, id_illegal, stall_pc, stall_if_id, flush_if_id,
           ex_alu_op, ex_alu_a_src, ex_alu_b_src, ex_is_branch, ex_is_jump,
           ex_br_type, ex_fwd_a, ex_fwd_b, mem_dm_wr, mem_dm_ctrl,
           wb_ru_wr, wb_rd, wb_data_src
  );
endinterface

// File: rtl/pipe_control_unit_decoder.sv
// Purely combinational RV32I opcode/funct decoder producing the ID-stage
// control word, the immediate format and the illegal-opcode flag.
module cu_decoder
  import cu_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  reg_addr_t  rs1,
  input  reg_addr_t  rs2,
  input  reg_addr_t  rd,
  output ctrl_t      ctrl,
  output imm_src_e   imm_src,
  output logic       illegal
);

  ctrl_t dec;
  logic  supported;

  // Only funct7[5] distinguishes RV32I operations.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Raw per-opcode decode, before validity and x0 qualification.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    dec       = CTRL_BUBBLE;
    imm_src   = IMM_I;
    supported = 1'b1;
    unique case (opcode)
      OPC_R: begin
        dec.alu_op  = alu_op_e'({funct7[5], funct3});
        dec.use_rs1 = 1'b1;
        dec.use_rs2 = 1'b1;
        dec.ru_wr   = 1'b1;
      end
      OPC_I: begin
        // funct7[5] only selects SRAI; addi/andi etc. ignore the upper bits.
        dec.alu_op    = (funct3 == 3'b101) ? alu_op_e'({funct7[5], funct3})
                                           : alu_op_e'({1'b0, funct3});
        dec.alu_b_src = 1'b1;
        dec.use_rs1   = 1'b1;
        dec.ru_wr     = 1'b1;
      end
      OPC_LOAD: begin
        dec.alu_b_src = 1'b1;
        dec.dm_ctrl   = funct3;
        dec.wb_src    = WB_DM;
        dec.use_rs1   = 1'b1;
        dec.ru_wr     = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_b_src = 1'b1;
        dec.dm_wr     = 1'b1;
        dec.dm_ctrl   = funct3;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
        imm_src       = IMM_S;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.br_type   = funct3;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
        imm_src       = IMM_B;
      end
      OPC_JAL: begin
        dec.alu_a_src = 1'b1;
        dec.alu_b_src = 1'b1;
        dec.is_jump   = 1'b1;
        dec.wb_src    = WB_PC4;
        dec.ru_wr     = 1'b1;
        imm_src       = IMM_J;
      end
      OPC_JALR: begin
        dec.alu_b_src = 1'b1;
        dec.is_jump   = 1'b1;
        dec.wb_src    = WB_PC4;
        dec.use_rs1   = 1'b1;
        dec.ru_wr     = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op    = ALU_PASSB;
        dec.alu_b_src = 1'b1;
        dec.ru_wr     = 1'b1;
        imm_src       = IMM_U;
      end
      OPC_AUIPC: begin
        dec.alu_a_src = 1'b1;
        dec.alu_b_src = 1'b1;
        dec.ru_wr     = 1'b1;
        imm_src       = IMM_U;
      end
      default: supported = 1'b0;
    endcase
  end

  // Qualify with validity, drop writes to x0, keep only used register fields.
  always_comb begin
    ctrl = CTRL_BUBBLE;
    if (id_valid && supported) begin
      ctrl       = dec;
      ctrl.valid = 1'b1;
      ctrl.ru_wr = dec.ru_wr && (rd != '0);
      ctrl.rd    = (dec.ru_wr && (rd != '0)) ? rd : '0;
      ctrl.rs1   = dec.use_rs1 ? rs1 : '0;
      ctrl.rs2   = dec.use_rs2 ? rs2 : '0;
    end
  end

  assign illegal = id_valid && !supported;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined RV32I control unit: decodes in ID, carries the control word
// through ID/EX, EX/MEM and MEM/WB, and resolves load-use stalls, branch
// flushes, data-memory stalls and operand forwarding.
module pipe_control_unit
  import cu_pkg::*;
#(
  parameter bit          ENABLE_FWD = 1'b1,
  parameter int unsigned RA_W       = CU_RA_W
) (
  input logic                clk,
  input logic                rst_n,
  pipe_control_unit_if.slave bus
);

  ctrl_t    id_ctrl;
  imm_src_e id_imm_src;
  logic     id_illegal;

  ctrl_t ex_q, ex_d;
  ctrl_t mem_q, mem_d;
  ctrl_t wb_q, wb_d;

  logic     load_use;
  logic     raw_no_fwd;
  logic     hazard;
  logic     stall_pc, stall_if_id, flush_if_id;
  fwd_sel_e fwd_a, fwd_b;

  cu_decoder u_decoder (
    .id_valid (bus.id_valid),
    .opcode   (bus.id_opcode),
    .funct3   (bus.id_funct3),
    .funct7   (bus.id_funct7),
    .rs1      (reg_addr_t'(bus.id_rs1)),
    .rs2      (reg_addr_t'(bus.id_rs2)),
    .rd       (reg_addr_t'(bus.id_rd)),
    .ctrl     (id_ctrl),
    .imm_src  (id_imm_src),
    .illegal  (id_illegal)
  );

  // Hazard detection: load-use with forwarding, any RAW against EX/MEM without.
  always_comb begin
    load_use   = (ex_q.wb_src == WB_DM) && raw_dep(id_ctrl, ex_q);
    raw_no_fwd = raw_dep(id_ctrl, ex_q) || raw_dep(id_ctrl, mem_q);
    hazard     = ENABLE_FWD ? load_use : raw_no_fwd;
  end

  // Pipeline advance: memory stall freezes, then flush, then hazard bubble.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    if (bus.mem_stall) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else if (bus.ex_branch_taken) begin
      flush_if_id = 1'b1;
      ex_d        = CTRL_BUBBLE;
      mem_d       = ex_q;
      wb_d        = mem_q;
    end else if (hazard) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      ex_d        = CTRL_BUBBLE;
      mem_d       = ex_q;
      wb_d        = mem_q;
    end else begin
      ex_d        = id_ctrl;
      mem_d       = ex_q;
      wb_d        = mem_q;
    end
  end

  // Pipeline registers; reset loads bubbles into every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all three
    // stages sample their inputs from the same pre-edge values.
    if (!rst_n) begin
      ex_q  <= CTRL_BUBBLE;
      mem_q <= CTRL_BUBBLE;
      wb_q  <= CTRL_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Forwarding selects: the younger EX/MEM result beats MEM/WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ENABLE_FWD) begin
      if (ex_q.use_rs1) begin
        if (writes_reg(mem_q, ex_q.rs1))     fwd_a = FWD_MEM;
        else if (writes_reg(wb_q, ex_q.rs1)) fwd_a = FWD_WB;
      end
      if (ex_q.use_rs2) begin
        if (writes_reg(mem_q, ex_q.rs2))     fwd_b = FWD_MEM;
        else if (writes_reg(wb_q, ex_q.rs2)) fwd_b = FWD_WB;
      end
    end
  end

  // Later stages only consume a subset of the carried control word.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{ex_q, mem_q, wb_q};

  assign bus.id_imm_src   = id_imm_src;
  assign bus.id_illegal   = id_illegal;
  assign bus.stall_pc     = stall_pc;
  assign bus.stall_if_id  = stall_if_id;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.ex_alu_op    = ex_q.alu_op;
  assign bus.ex_alu_a_src = ex_q.alu_a_src;
  assign bus.ex_alu_b_src = ex_q.alu_b_src;
  assign bus.ex_is_branch = ex_q.is_branch;
  assign bus.ex_is_jump   = ex_q.is_jump;
  assign bus.ex_br_type   = ex_q.br_type;
  assign bus.ex_fwd_a     = fwd_a;
  assign bus.ex_fwd_b     = fwd_b;
  assign bus.mem_dm_wr    = mem_q.dm_wr;
  assign bus.mem_dm_ctrl  = mem_q.dm_ctrl;
  assign bus.wb_ru_wr     = wb_q.ru_wr;
  assign bus.wb_rd        = RA_W'(wb_q.rd);
  assign bus.wb_data_src  = wb_q.wb_src;

endmodule
